// File: rtl/wb_trace_arbiter.sv
// Merges the dual-issue writeback slots into one in-order trace port.
// Writing commits queue in a small FIFO that drains one entry per cycle.
module wb_trace_arbiter #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  input  logic [31:0] wb0_pc,
  input  logic        wb0_wen,
  input  logic [4:0]  wb0_wnum,
  input  logic [31:0] wb0_wdata,
  input  logic        wb1_valid,
  input  logic [31:0] wb1_pc,
  input  logic        wb1_wen,
  input  logic [4:0]  wb1_wnum,
  input  logic [31:0] wb1_wdata,
  output logic        trace_allowin,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] commit_cnt,
  output logic        proto_err
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  localparam logic [PTR_W:0] LIMIT = (PTR_W+1)'(DEPTH - 2);

  ent_t             mem [DEPTH];
  ent_t             ent0;
  ent_t             ent1;
  ent_t             head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr1;
  logic [PTR_W-1:0] waddr1;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic [1:0]       npush;
  logic             wr0;
  logic             wr1;
  logic             push0;
  logic             push1;
  logic             pop;

  assign ent0 = '{pc: wb0_pc, wnum: wb0_wnum, wdata: wb0_wdata};
  assign ent1 = '{pc: wb1_pc, wnum: wb1_wnum, wdata: wb1_wdata};

  assign wr0 = wb0_valid & wb0_wen & (wb0_wnum != 5'd0);
  assign wr1 = wb1_valid & wb1_wen & (wb1_wnum != 5'd0);

  assign push0 = trace_allowin & wr0;
  assign push1 = trace_allowin & wr1;
  assign npush = {1'b0, push0} + {1'b0, push1};
  assign pop   = (count != '0);

  // slot1 lands behind slot0 only when slot0 also wrote
  assign wptr1  = wptr + 1'b1;
  assign waddr1 = push0 ? wptr1 : wptr;
  assign head   = mem[rptr];

  assign count_next = count
                    + (PTR_W+1)'(npush)
                    - (PTR_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (push0) mem[wptr]   <= ent0;
    if (push1) mem[waddr1] <= ent1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr              <= '0;
      rptr              <= '0;
      count             <= '0;
      trace_allowin     <= 1'b0;
      proto_err         <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      commit_cnt        <= '0;
    end else begin
      wptr          <= wptr + PTR_W'(npush);
      count         <= count_next;
      trace_allowin <= (count_next <= LIMIT);
      if (!trace_allowin && (wb0_valid || wb1_valid))
        proto_err <= 1'b1;
      if (pop) begin
        rptr              <= rptr + 1'b1;
        debug_wb_pc       <= head.pc;
        debug_wb_rf_wen   <= 4'hf;
        debug_wb_rf_wnum  <= head.wnum;
        debug_wb_rf_wdata <= head.wdata;
        commit_cnt        <= commit_cnt + 32'd1;
      end else begin
        debug_wb_rf_wen <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_arbiter.sv
// Directed and randomized bench for wb_trace_arbiter.
// A queue-based reference model predicts every trace output.
module tb_wb_trace_arbiter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb0_wen, wb1_valid, wb1_wen;
  logic [31:0] wb0_pc, wb0_wdata, wb1_pc, wb1_wdata;
  logic [4:0]  wb0_wnum, wb1_wnum;
  logic        trace_allowin;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] commit_cnt;
  logic        proto_err;

  wb_trace_arbiter #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_pc(wb0_pc), .wb0_wen(wb0_wen),
    .wb0_wnum(wb0_wnum), .wb0_wdata(wb0_wdata),
    .wb1_valid(wb1_valid), .wb1_pc(wb1_pc), .wb1_wen(wb1_wen),
    .wb1_wnum(wb1_wnum), .wb1_wdata(wb1_wdata),
    .trace_allowin(trace_allowin),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .commit_cnt(commit_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  ent_t        q[$];
  logic        m_allow;
  logic [31:0] e_pc, e_wdata, e_cnt;
  logic [4:0]  e_wnum;
  logic [3:0]  e_wen;
  logic        e_err;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("allowin", 32'(trace_allowin), 32'(m_allow));
    check("rf_wen", 32'(debug_wb_rf_wen), 32'(e_wen));
    check("pc", debug_wb_pc, e_pc);
    check("wnum", 32'(debug_wb_rf_wnum), 32'(e_wnum));
    check("wdata", debug_wb_rf_wdata, e_wdata);
    check("commit_cnt", commit_cnt, e_cnt);
    check("proto_err", 32'(proto_err), 32'(e_err));
  endtask

  task automatic set0(input logic v, input logic [31:0] pc,
                      input logic we, input logic [4:0] n,
                      input logic [31:0] d);
    wb0_valid = v; wb0_pc = pc; wb0_wen = we;
    wb0_wnum = n; wb0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic [31:0] pc,
                      input logic we, input logic [4:0] n,
                      input logic [31:0] d);
    wb1_valid = v; wb1_pc = pc; wb1_wen = we;
    wb1_wnum = n; wb1_wdata = d;
  endtask

  task automatic idle();
    set0(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set1(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // one clock edge: advance the reference model, then compare
  task automatic step();
    ent_t h;
    logic had;
    @(posedge clk);
    had = (q.size() != 0);
    if (had) begin
      h = q.pop_front();
      e_pc = h.pc; e_wnum = h.wnum; e_wdata = h.wdata;
      e_wen = 4'hf;
      e_cnt = e_cnt + 1;
    end else begin
      e_wen = 4'h0;
    end
    if (m_allow) begin
      if (wb0_valid && wb0_wen && wb0_wnum != 0)
        q.push_back('{wb0_pc, wb0_wnum, wb0_wdata});
      if (wb1_valid && wb1_wen && wb1_wnum != 0)
        q.push_back('{wb1_pc, wb1_wnum, wb1_wdata});
    end else if (wb0_valid || wb1_valid) begin
      e_err = 1'b1;
    end
    m_allow = (q.size() <= DEPTH - 2);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    q.delete();
    m_allow = 0; e_pc = 0; e_wdata = 0; e_cnt = 0;
    e_wnum = 0; e_wen = 0; e_err = 0;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    int n_wr;
    int done;
    logic [31:0] pc;
    logic [31:0] cnt0;
    rst = 1'b1;
    idle();
    #2;
    do_reset();

    // single commit
    step();
    set0(1'b1, 32'hbfc00000, 1'b1, 5'd5, 32'h1234);
    step();
    idle();
    step();
    check("single_pc", debug_wb_pc, 32'hbfc00000);
    check("single_wen", 32'(debug_wb_rf_wen), 32'hf);
    step();
    check("single_wen_off", 32'(debug_wb_rf_wen), 32'h0);
    check("single_cnt", commit_cnt, 32'd1);

    // dual ordering
    set0(1'b1, 32'h100, 1'b1, 5'd1, 32'haa);
    set1(1'b1, 32'h104, 1'b1, 5'd2, 32'hbb);
    step();
    idle();
    step();
    check("dual_first", debug_wb_pc, 32'h100);
    step();
    check("dual_second", debug_wb_pc, 32'h104);

    // filtering
    set0(1'b1, 32'h200, 1'b0, 5'd3, 32'h1);
    set1(1'b1, 32'h204, 1'b1, 5'd0, 32'h2);
    step();
    idle();
    step();
    check("filter_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("filter_cnt", commit_cnt, 32'd3);

    // backpressure: valid held even while allowin is low
    pc = 32'h1000;
    for (int i = 0; i < 16; i++) begin
      set0(1'b1, pc, 1'b1, 5'd7, pc ^ 32'h55);
      set1(1'b1, pc + 4, 1'b1, 5'd8, pc ^ 32'haa);
      pc = pc + 8;
      step();
    end
    idle();
    for (int i = 0; i < 10; i++) step();
    check("bp_err", 32'(proto_err), 32'h1);

    // async reset with five entries buffered
    do_reset();
    step();
    pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, pc, 1'b1, 5'd9, pc);
      set1(1'b1, pc + 4, 1'b1, 5'd10, pc);
      pc = pc + 8;
      step();
    end
    #2;
    do_reset();
    check("rst_pc", debug_wb_pc, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("rst_allow", 32'(trace_allowin), 32'h1);
    check("rst_no_stale", commit_cnt, 32'd0);

    // randomized mixed commits through pointer wrap
    cnt0 = commit_cnt;
    n_wr = 0;
    done = 0;
    pc = 32'h8000;
    for (int i = 0; i < 400 && done < 40; i++) begin
      idle();
      if (m_allow) begin
        int kind;
        logic we0, we1;
        logic [4:0] n0, n1;
        kind = $urandom_range(0, 2);
        we0 = 1'($urandom_range(0, 3) != 0);
        we1 = 1'($urandom_range(0, 3) != 0);
        n0 = 5'($urandom_range(0, 31));
        n1 = 5'($urandom_range(0, 31));
        if (kind != 1) begin
          set0(1'b1, pc, we0, n0, $urandom);
          pc = pc + 4;
          if (we0 && n0 != 0) n_wr++;
        end
        if (kind != 0) begin
          set1(1'b1, pc, we1, n1, $urandom);
          pc = pc + 4;
          if (we1 && n1 != 0) n_wr++;
        end
        done++;
      end
      step();
    end
    idle();
    for (int i = 0; i < 12; i++) step();
    check("rand_done", 32'(done), 32'd40);
    check("rand_cnt", commit_cnt - cnt0, 32'(n_wr));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_arbiter.md
Name: wb_trace_arbiter

Overview:
- Merges the two writeback slots of the dual-issue core (slot0 = primary/older, slot1 = secondary/younger) into the single debug trace port used by the golden-trace comparator.
- Buffers register-writing commits in program order in a small FIFO and drains exactly one per cycle.
- Throttles writeback through a registered allowin when the buffer cannot absorb a worst-case two-commit cycle.
- Also keeps a sticky protocol-error flag and a commit counter for performance and debug.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- wb0_valid  in  1  slot0 commit valid.
- wb0_pc  in  32  slot0 commit PC.
- wb0_wen  in  1  slot0 writes a GPR.
- wb0_wnum  in  5  slot0 destination GPR.
- wb0_wdata  in  32  slot0 write data.
- wb1_valid, wb1_pc, wb1_wen, wb1_wnum, wb1_wdata  in  1/32/1/5/32  same fields for slot1.
- trace_allowin  out  1  writeback may commit this cycle.
- debug_wb_pc  out  32  trace PC.
- debug_wb_rf_wen  out  4  trace byte write enable; 4'hf or 0.
- debug_wb_rf_wnum  out  5  trace destination GPR.
- debug_wb_rf_wdata  out  32  trace write data.
- commit_cnt  out  32  number of entries emitted on the trace port.
- proto_err  out  1  sticky flag: commit offered while not allowed.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FIFO pointers and count 0. trace_allowin is 0 while reset is asserted and becomes 1 at the first clock edge after release.
- Entry qualification: an entry is writing when valid && wen && (wnum != 0). Non-writing commits are consumed (they still count as committed for pipeline purposes) but are never enqueued.
- Handshake: trace_allowin is a registered value, 1 when count <= DEPTH-2 after the current cycle's update, so it does not depend combinationally on wb*_valid.
- Commits are accepted only on edges where trace_allowin=1.
- A valid on either slot while trace_allowin=0 is ignored and sets proto_err (cleared only by reset).
- Ordering: when both slots are writing in the same cycle, slot0 goes to wptr and slot1 to wptr+1. A single writing entry (from either slot) goes to wptr.
- wptr advances by 0, 1 or 2, modulo DEPTH; wrap-around is natural pointer overflow.
- Drain: on each edge where count != 0 (value before the edge), the head entry is loaded into the debug_* output registers. On that edge debug_wb_rf_wen=4'hf, rptr+1, and commit_cnt+1 (wraps at 2^32).
- When count == 0 on an edge, debug_wb_rf_wen<=0 and pc/wnum/wdata hold their previous values.
- Latency: an entry accepted at edge N appears on the debug outputs after edge N+1 at the earliest, with no bypass path. Each entry is presented for exactly one cycle.
- Count update: count_next = count + pushes - pop. Pushes is 0..2 and pop is 0..1, so push2 + pop1 gives +1 and push1 + pop1 gives 0.
- Full and empty are derived from count (0..DEPTH, width PTR_W+1), not from pointer equality.
- The allowin rule guarantees count never exceeds DEPTH. Ignored offers while allowin=0 never corrupt FIFO contents.
- Reset mid-operation: all buffered entries are discarded immediately; no partial trace output occurs after reset release.

Test Plan:
- Single commit: after reset, one cycle wb0_valid=1, wen=1, wnum=5, wdata=32'h1234, pc=32'hbfc00000 at edge N → after edge N+1: wen=4'hf, wnum=5, wdata=32'h1234, pc=32'hbfc00000. After edge N+2: wen=0 and other fields unchanged. commit_cnt=1.
- Dual ordering: both slots writing in the same cycle (slot0 pc=0x100, wnum=1; slot1 pc=0x104, wnum=2) → pc 0x100 appears after edge N+1, then pc 0x104 after edge N+2.
- Filtering: slot0 wen=0, slot1 wnum=0, both valid → nothing enqueued, trace wen stays 0, commit_cnt unchanged.
- Backpressure: dual writing commits every cycle with DEPTH=8 → trace_allowin falls to 0 once count reaches 7 and stays 0 until count <= 6. The emitted trace is a gap-free, in-order PC sequence with no loss or duplication. Holding valid high through allowin=0 sets proto_err=1.
- Wrap-around: 40 mixed single and dual commits → trace PCs are exactly the writing entries in program order and commit_cnt=number of writing entries.
- Async reset: assert rst=0 mid-cycle with 5 entries buffered → all outputs 0 immediately. After release, no stale entries are emitted and trace_allowin=1 after one edge.
